// File: rtl/wishbone_burst_master.sv
// ---------------------------------------------------------------------------
// wishbone_burst_master
//
// CPU-to-Wishbone classic master. A CPU request is latched into output flops
// on accept, and the bus cycle is driven entirely from registers. Features:
// burst continuation (cyc held open between beats), bounded wb_rty retry with
// a one-cycle back-off gap, wb_err reporting, and a busy flag.
//
// Optional feature macro: WISHBONE_BURST_MASTER_TIMEOUT_EN
//   When defined, a strobe watchdog aborts an access with o_mem_err after
//   TIMEOUT_CYC strobe cycles with no slave response. When undefined, the
//   strobe phase waits indefinitely.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_mem_addr/data/sel   CPU address, write data, byte selects
//   i_mem_req, i_mem_we   request (taken only while o_mem_busy=0), write enable
//   i_mem_next            keep the bus cycle open after this access (burst)
//   o_mem_data, o_mem_ack read data and one-cycle completion pulse
//   o_mem_err             one-cycle failure pulse
//   o_mem_busy            access in flight (including the ack/err cycle)
//   wb_cyc/stb/we/adr/o_dat/sel   Wishbone master outputs (all registered)
//   wb_i_dat, wb_ack/err/rty      Wishbone slave read data and responses
// ---------------------------------------------------------------------------
module wishbone_burst_master #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 24,
    parameter int SEL_W       = DATA_W / 8,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [SEL_W-1:0]  i_mem_sel,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic              i_mem_next,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_ack,
    output logic              o_mem_err,
    output logic              o_mem_busy,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [DATA_W-1:0] wb_o_dat,
    output logic [SEL_W-1:0]  wb_sel,
    input  logic [DATA_W-1:0] wb_i_dat,
    input  logic              wb_ack,
    input  logic              wb_err,
    input  logic              wb_rty
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

    // Retry counter is just wide enough to hold MAX_RETRY and never wraps.
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
    localparam logic [RTY_W-1:0] RTY_ZERO = {RTY_W{1'b0}};

    // Configuration sanity checks, evaluated at elaboration.
    if ((DATA_W % 8) != 0 || SEL_W != DATA_W / 8) begin : g_bad_width
        $error("wishbone_burst_master: DATA_W must be a multiple of 8 and SEL_W = DATA_W/8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("wishbone_burst_master: TIMEOUT_CYC must be at least 1");
    end

    state_t             state_r;
    logic               cyc_r;
    logic               stb_r;
    logic               we_r;
    logic [ADDR_W-1:0]  adr_r;
    logic [DATA_W-1:0]  wdat_r;
    logic [SEL_W-1:0]   sel_r;
    logic [DATA_W-1:0]  rdat_r;
    logic               ack_r;
    logic               err_r;
    logic               busy_r;
    logic               next_r;
    logic [RTY_W-1:0]   rty_cnt_r;

    logic               accept_s;
    logic               rty_ok_s;
    logic               fail_s;
    logic               tmo_hit_s;

    // A request is taken only when nothing is in flight, from IDLE or a burst gap.
    always_comb begin
        if (i_mem_req && !busy_r && (state_r == ST_IDLE || state_r == ST_HOLD)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Failure decode: wb_err, a retry beyond the budget, or the watchdog when the
    // slave is silent. wb_ack is checked ahead of this in the FSM, so ack wins.
    always_comb begin
        rty_ok_s = (rty_cnt_r < RTY_MAX);
        if (wb_rty) begin
            fail_s = wb_err | ~rty_ok_s;
        end else begin
            fail_s = wb_err | tmo_hit_s;
        end
    end

`ifdef WISHBONE_BURST_MASTER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

    logic [TMO_W-1:0] tmo_cnt_r;

    // The counter holds the number of silent strobe cycles already completed,
    // so the abort fires on the TIMEOUT_CYC-th silent strobe cycle.
    always_comb begin
        if (state_r == ST_STROBE && tmo_cnt_r == TMO_LAST) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Watchdog counter: cleared on every entry to STROBE, frozen outside STROBE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if (accept_s || state_r == ST_BACKOFF) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if (state_r == ST_STROBE && !(wb_ack || wb_err || wb_rty) && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    // No watchdog in this build: the strobe phase waits for the slave.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Main FSM: all bus and CPU-side outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            we_r      <= 1'b0;
            adr_r     <= {ADDR_W{1'b0}};
            wdat_r    <= {DATA_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            rdat_r    <= {DATA_W{1'b0}};
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            next_r    <= 1'b0;
            rty_cnt_r <= RTY_ZERO;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (accept_s) begin
                adr_r     <= i_mem_addr;
                wdat_r    <= i_mem_data;
                sel_r     <= i_mem_sel;
                we_r      <= i_mem_we;
                next_r    <= i_mem_next;
                rty_cnt_r <= RTY_ZERO;
                cyc_r     <= 1'b1;
                stb_r     <= 1'b1;
                busy_r    <= 1'b1;
                state_r   <= ST_STROBE;
            end else begin
                case (state_r)
                    ST_STROBE: begin
                        if (wb_ack) begin
                            rdat_r  <= wb_i_dat;
                            ack_r   <= 1'b1;
                            stb_r   <= 1'b0;
                            cyc_r   <= next_r;
                            state_r <= next_r ? ST_HOLD : ST_IDLE;
                        end else if (fail_s) begin
                            // cyc drops even mid-burst: the whole burst is abandoned.
                            err_r   <= 1'b1;
                            stb_r   <= 1'b0;
                            cyc_r   <= 1'b0;
                            state_r <= ST_IDLE;
                        end else if (wb_rty) begin
                            rty_cnt_r <= rty_cnt_r + RTY_ONE;
                            stb_r     <= 1'b0;
                            state_r   <= ST_BACKOFF;
                        end else begin
                            state_r <= ST_STROBE;
                        end
                    end
                    ST_BACKOFF: begin
                        // Reissue the identical latched access after one idle-strobe cycle.
                        stb_r   <= 1'b1;
                        state_r <= ST_STROBE;
                    end
                    ST_HOLD: begin
                        // Busy here only during the ack pulse; i_mem_next still decides
                        // whether the burst stays open.
                        busy_r <= 1'b0;
                        if (!i_mem_next) begin
                            cyc_r   <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                        cyc_r  <= 1'b0;
                        stb_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cyc_r   <= 1'b0;
                        stb_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wb_cyc     = cyc_r;
    assign wb_stb     = stb_r;
    assign wb_we      = we_r;
    assign wb_adr     = adr_r;
    assign wb_o_dat   = wdat_r;
    assign wb_sel     = sel_r;
    assign o_mem_data = rdat_r;
    assign o_mem_ack  = ack_r;
    assign o_mem_err  = err_r;
    assign o_mem_busy = busy_r;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// ---------------------------------------------------------------------------
// Self-checking bench for wishbone_burst_master. An access-level reference
// model predicts every output each cycle; directed scenarios add literal
// expectations, followed by a randomized CPU/slave phase.
// ---------------------------------------------------------------------------
module tb_wishbone_burst_master;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 24;
    localparam int SEL_W       = 2;
    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [ADDR_W-1:0] i_mem_addr = '0;
    logic [DATA_W-1:0] i_mem_data = '0;
    logic [SEL_W-1:0]  i_mem_sel = '0;
    logic              i_mem_req = 1'b0;
    logic              i_mem_we = 1'b0;
    logic              i_mem_next = 1'b0;
    logic [DATA_W-1:0] o_mem_data;
    logic              o_mem_ack, o_mem_err, o_mem_busy;
    logic              wb_cyc, wb_stb, wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_o_dat;
    logic [SEL_W-1:0]  wb_sel;
    logic [DATA_W-1:0] wb_i_dat = '0;
    logic              wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    wishbone_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
        .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_sel(i_mem_sel),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_next(i_mem_next),
        .o_mem_data(o_mem_data), .o_mem_ack(o_mem_ack), .o_mem_err(o_mem_err),
        .o_mem_busy(o_mem_busy),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_i_dat(wb_i_dat),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- slave: scripted responses {ack,err,rty} per strobe cycle
    logic [2:0]        script_q[$];
    bit                rand_mode = 1'b0;
    bit                fix_dat = 1'b0;
    logic [DATA_W-1:0] fix_val = '0;

    always @(posedge i_clk) begin
        logic [2:0] r;
        int p;
        #1;
        r = 3'b000;
        if (wb_stb) begin
            if (script_q.size() > 0) begin
                r = script_q.pop_front();
            end else if (rand_mode) begin
                p = $urandom_range(0, 19);
                if (p <= 8)       r = 3'b100;
                else if (p == 9)  r = 3'b110;
                else if (p == 10) r = 3'b101;
                else if (p <= 12) r = 3'b010;
                else if (p <= 16) r = 3'b001;
                else              r = 3'b000;
            end else begin
                r = 3'b100;
            end
        end
        {wb_ack, wb_err, wb_rty} = r;
        wb_i_dat = fix_dat ? fix_val : DATA_W'($urandom);
    end

    // ---------------- reference model (access-level view of the master)
    bit                e_cyc = 0, e_stb = 0, e_we = 0, e_ack = 0, e_err = 0, e_busy = 0;
    logic [ADDR_W-1:0] e_adr = '0;
    logic [DATA_W-1:0] e_wdat = '0, e_rdat = '0;
    logic [SEL_W-1:0]  e_sel = '0;
    bit                m_next = 0, m_backoff = 0;
    int                m_rtys = 0, m_wait = 0;

    task automatic model_abort();
        e_err = 1; e_stb = 0; e_cyc = 0;
    endtask

    task automatic model_step();
        bit was_busy;
        if (i_rst) begin
            e_cyc = 0; e_stb = 0; e_we = 0; e_ack = 0; e_err = 0; e_busy = 0;
            e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0;
            m_next = 0; m_backoff = 0; m_rtys = 0; m_wait = 0;
            return;
        end
        was_busy = e_busy;
        e_ack = 0;
        e_err = 0;
        if (!was_busy && i_mem_req) begin
            e_adr = i_mem_addr; e_wdat = i_mem_data; e_sel = i_mem_sel; e_we = i_mem_we;
            m_next = i_mem_next; m_rtys = 0; m_wait = 0;
            e_cyc = 1; e_stb = 1; e_busy = 1;
        end else if (e_stb) begin
            if (wb_ack) begin
                e_rdat = wb_i_dat; e_ack = 1; e_stb = 0; e_cyc = m_next;
            end else if (wb_err || (wb_rty && m_rtys == MAX_RETRY)) begin
                model_abort();
            end else if (wb_rty) begin
                m_rtys++; e_stb = 0; m_backoff = 1;
            end else begin
`ifdef WISHBONE_BURST_MASTER_TIMEOUT_EN
                m_wait++;
                if (m_wait == TIMEOUT_CYC) model_abort();
`endif
            end
        end else if (m_backoff) begin
            m_backoff = 0; e_stb = 1; m_wait = 0;
        end else begin
            e_busy = 0;
            if (!i_mem_next) e_cyc = 0;
        end
    endtask

    always @(posedge i_clk) model_step();

    // ---------------- per-cycle comparison against the model
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("cmp_wb_cyc", wb_cyc, e_cyc);
            chk("cmp_wb_stb", wb_stb, e_stb);
            chk("cmp_wb_we", wb_we, e_we);
            chk("cmp_wb_adr", wb_adr, e_adr);
            chk("cmp_wb_o_dat", wb_o_dat, e_wdat);
            chk("cmp_wb_sel", wb_sel, e_sel);
            chk("cmp_o_mem_data", o_mem_data, e_rdat);
            chk("cmp_o_mem_ack", o_mem_ack, e_ack);
            chk("cmp_o_mem_err", o_mem_err, e_err);
            chk("cmp_o_mem_busy", o_mem_busy, e_busy);
        end
    end

    // ---------------- CPU-side helpers
    task automatic cpu_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [SEL_W-1:0] s, input bit we, input bit nx);
        @(posedge i_clk); #1;
        i_mem_addr = a; i_mem_data = d; i_mem_sel = s; i_mem_we = we;
        i_mem_next = nx; i_mem_req = 1'b1;
        @(posedge i_clk); #1;
        i_mem_req = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit got_ack, output bit got_err,
                             output int bo, output int stbc, output bit adr_stable,
                             output logic [ADDR_W-1:0] adr0, output logic [DATA_W-1:0] dat0,
                             output bit we0);
        got_ack = 0; got_err = 0; bo = 0; stbc = 0; adr_stable = 1;
        adr0 = '0; dat0 = '0; we0 = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge i_clk);
            if (wb_stb) begin
                if (stbc == 0) begin
                    adr0 = wb_adr; dat0 = wb_o_dat; we0 = wb_we;
                end else if (wb_adr !== adr0) begin
                    adr_stable = 0;
                end
                stbc++;
            end
            if (o_mem_ack || o_mem_err) begin
                got_ack = o_mem_ack;
                got_err = o_mem_err;
                return;
            end
            if (wb_cyc && !wb_stb && o_mem_busy) bo++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_done at %0t: no ack/err within %0d cycles", $time, bound);
    endtask

    bit                ga, ge, ast, w0;
    int                bo, sc;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;

    initial begin
        // reset
        repeat (2) @(posedge i_clk);
        #1 chk_en = 1'b1;
        @(negedge i_clk);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_ack", o_mem_ack, 0);
        chk("rst_err", o_mem_err, 0);
        chk("rst_busy", o_mem_busy, 0);
        chk("rst_data", o_mem_data, 0);
        @(posedge i_clk); #1 i_rst = 1'b0;

        // single read, slave answers on the third strobe cycle
        fix_dat = 1'b1; fix_val = 16'hBEEF;
        script_q = '{3'b000, 3'b000, 3'b100};
        cpu_req(24'h001234, 16'h0000, 2'b11, 1'b0, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("rd_ack", ga, 1);
        chk("rd_err", ge, 0);
        chk("rd_stb_cycles", sc, 3);
        chk("rd_adr", a0, 24'h001234);
        chk("rd_data", o_mem_data, 16'hBEEF);
        chk("rd_model_data", e_rdat, 16'hBEEF);
        chk("rd_cyc_at_ack", wb_cyc, 0);
        chk("rd_busy_at_ack", o_mem_busy, 1);
        @(negedge i_clk);
        chk("rd_busy_after", o_mem_busy, 0);
        chk("rd_single_ack", o_mem_ack, 0);
        fix_dat = 1'b0;

        // burst write of three beats
        for (int i = 0; i < 3; i++) begin
            bit nx;
            nx = (i < 2);
            cpu_req(24'h000010 + ADDR_W'(i), 16'h00A1 + DATA_W'(i), 2'b11, 1'b1, nx);
            wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
            chk("bw_ack", ga, 1);
            chk("bw_adr", a0, 32'h10 + i);
            chk("bw_dat", d0, 32'hA1 + i);
            chk("bw_we", w0, 1);
            chk("bw_cyc_at_ack", wb_cyc, nx);
            if (nx) begin
                @(negedge i_clk);
                chk("bw_hold_cyc", wb_cyc, 1);
                chk("bw_hold_stb", wb_stb, 0);
                chk("bw_hold_busy", o_mem_busy, 0);
            end
        end

        // two retries then ack
        script_q = '{3'b001, 3'b001, 3'b100};
        cpu_req(24'h000555, 16'h1357, 2'b01, 1'b1, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("rty_ack", ga, 1);
        chk("rty_err", ge, 0);
        chk("rty_backoffs", bo, 2);
        chk("rty_strobes", sc, 3);
        chk("rty_same_adr", ast, 1);
        chk("rty_adr", a0, 24'h000555);
        @(negedge i_clk);
        chk("rty_single_ack", o_mem_ack, 0);

        // retry budget exhausted on the fourth wb_rty
        script_q = '{3'b001, 3'b001, 3'b001, 3'b001};
        cpu_req(24'h000777, 16'h0000, 2'b11, 1'b0, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("rtx_err", ge, 1);
        chk("rtx_ack", ga, 0);
        chk("rtx_backoffs", bo, 3);
        chk("rtx_strobes", sc, 4);
        chk("rtx_cyc", wb_cyc, 0);
        @(negedge i_clk);
        chk("rtx_err_once", o_mem_err, 0);
        chk("rtx_busy_after", o_mem_busy, 0);

        // ack and err together count as ack
        script_q = '{3'b110};
        cpu_req(24'h000020, 16'h0000, 2'b11, 1'b0, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("ackerr_ack", ga, 1);
        chk("ackerr_err", ge, 0);

        // wb_err in the middle of a burst closes the cycle
        cpu_req(24'h000030, 16'h0001, 2'b11, 1'b1, 1'b1);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("berr_first_ack", ga, 1);
        script_q = '{3'b010};
        cpu_req(24'h000031, 16'h0002, 2'b11, 1'b1, 1'b1);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("berr_err", ge, 1);
        chk("berr_cyc", wb_cyc, 0);
        i_mem_next = 1'b0;

        // reset while strobing
        for (int i = 0; i < 10; i++) script_q.push_back(3'b000);
        cpu_req(24'h000040, 16'h0000, 2'b11, 1'b0, 1'b0);
        @(posedge i_clk); #1 i_rst = 1'b1;
        @(negedge i_clk);
        chk("mrst_stb_before", wb_stb, 1);
        @(negedge i_clk);
        chk("mrst_cyc", wb_cyc, 0);
        chk("mrst_stb", wb_stb, 0);
        chk("mrst_busy", o_mem_busy, 0);
        chk("mrst_ack", o_mem_ack, 0);
        chk("mrst_err", o_mem_err, 0);
        i_rst = 1'b0;
        script_q.delete();
        @(negedge i_clk);
        chk("mrst_ack_after", o_mem_ack, 0);
        chk("mrst_err_after", o_mem_err, 0);

`ifdef WISHBONE_BURST_MASTER_TIMEOUT_EN
        // silent slave: watchdog aborts after TIMEOUT_CYC strobe cycles
        for (int i = 0; i < 20; i++) script_q.push_back(3'b000);
        cpu_req(24'h000050, 16'h0000, 2'b11, 1'b0, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("tmo_err", ge, 1);
        chk("tmo_ack", ga, 0);
        chk("tmo_strobes", sc, 8);
        script_q.delete();
`else
        // without the watchdog a slow slave is simply waited for
        for (int i = 0; i < 12; i++) script_q.push_back(3'b000);
        script_q.push_back(3'b100);
        cpu_req(24'h000050, 16'h0000, 2'b11, 1'b0, 1'b0);
        wait_done(40, ga, ge, bo, sc, ast, a0, d0, w0);
        chk("slow_ack", ga, 1);
        chk("slow_strobes", sc, 13);
`endif

        // randomized phase: random CPU traffic, random slave, rare resets
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge i_clk); #1;
            i_rst      = ($urandom_range(0, 199) == 0);
            i_mem_req  = ($urandom_range(0, 2) == 0);
            i_mem_addr = ADDR_W'($urandom);
            i_mem_data = DATA_W'($urandom);
            i_mem_sel  = SEL_W'($urandom);
            i_mem_we   = 1'($urandom_range(0, 1));
            i_mem_next = 1'($urandom_range(0, 1));
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_mem_req = 1'b0; i_mem_next = 1'b0; rand_mode = 1'b0;
        repeat (20) @(posedge i_clk);
        @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_burst_master.md
Name: wishbone_burst_master

Overview:
- Parametrised CPU-to-Wishbone classic master; next generation of the CPU memory adapter.
- Registered master side: the request is latched on accept, and wb_cyc/wb_stb/wb_adr/wb_we/wb_sel/wb_o_dat are all driven from flops.
- Adds burst continuation with a held bus cycle, wb_rty retry with a bounded count, wb_err reporting, a busy flag, and an optional timeout watchdog.
- Sits between the CPU memory port and the Wishbone interconnect.

Parameters:
DATA_W, 16, data bus width; must be a multiple of 8
ADDR_W, 24, address width
SEL_W, DATA_W/8, byte-select width
MAX_RETRY, 3, number of wb_rty responses tolerated per access; the next one raises an error
TIMEOUT_CYC, 255, strobe cycles without a response before abort (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_mem_addr  in  ADDR_W  CPU address
i_mem_data  in  DATA_W  CPU write data
i_mem_sel  in  SEL_W  byte selects
i_mem_req  in  1  request; accepted only when o_mem_busy=0
i_mem_we  in  1  write enable
i_mem_next  in  1  keep the bus cycle open after this access (burst)
o_mem_data  out  DATA_W  read data; valid with o_mem_ack
o_mem_ack  out  1  one-cycle access-complete pulse
o_mem_err  out  1  one-cycle access-failed pulse
o_mem_busy  out  1  access in flight
wb_cyc, wb_stb, wb_we  out  1  Wishbone cycle, strobe and write enable
wb_adr  out  ADDR_W  Wishbone address
wb_o_dat  out  DATA_W  Wishbone write data
wb_sel  out  SEL_W  Wishbone byte selects
wb_i_dat  in  DATA_W  Wishbone read data
wb_ack, wb_err, wb_rty  in  1  Wishbone slave responses

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: state IDLE; all wb_* outputs 0; o_mem_ack=0; o_mem_err=0; o_mem_busy=0; o_mem_data=0; retry count 0.
- Reset mid-access: cyc/stb fall at that edge; no ack or err is issued for the aborted access.
- States:
  - IDLE: cyc=0, stb=0.
  - STROBE: cyc=1, stb=1.
  - HOLD: burst gap; cyc=1, stb=0.
  - BACKOFF: retry gap; cyc=1, stb=0, one cycle.
- Accept (IDLE or HOLD, i_mem_req=1):
  - Latch addr, data, sel and we into the wb_* flops; latch next_flag = i_mem_next.
  - Go to STROBE; stb rises on the edge after the req cycle.
  - Clear the retry count.
- o_mem_busy=1 in STROBE and BACKOFF, and also in the cycle o_mem_ack/o_mem_err pulses. CPU inputs other than i_mem_next are don't-care while busy.
- Response priority when several are asserted in one cycle: wb_ack > wb_err > wb_rty.
- STROBE + wb_ack:
  - o_mem_data <= wb_i_dat; o_mem_ack=1 in the next cycle.
  - If next_flag=1, go to HOLD; otherwise go to IDLE and drop cyc.
  - Minimum access latency: req at edge N, stb high from N+1, ack at N+1, o_mem_ack at N+2.
- STROBE + wb_err: o_mem_err pulses next cycle; go to IDLE; cyc drops regardless of next_flag.
- STROBE + wb_rty:
  - If retry count < MAX_RETRY: increment count, go to BACKOFF, then return to STROBE with identical latched address/data.
  - Otherwise: handle as wb_err.
- HOLD:
  - Accept a new request as above; wb_adr updates on the accept edge. cyc stays 1 throughout the burst.
  - If i_mem_req=0 and i_mem_next=0: go to IDLE, drop cyc.
  - HOLD may last any number of cycles.
- o_mem_ack and o_mem_err are never asserted together and never for two consecutive cycles for the same access.
- wb_stb is never high in IDLE, HOLD or BACKOFF.
- The retry counter is ceil(log2(MAX_RETRY+1)) bits wide and saturates; no wrap-around.

Optional Feature:
- Macro: WISHBONE_BURST_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to STROBE and increments every STROBE cycle with no response.
  - When it reaches TIMEOUT_CYC: o_mem_err pulses, go to IDLE, cyc drops.
  - A response arriving in the same cycle as the timeout wins over the timeout.
  - The counter does not run in HOLD or BACKOFF.
- Undefined: no counter logic; STROBE waits indefinitely for a response.

Test Plan:
- Single read: req addr=0x001234, slave acks 2 cycles later with 0xBEEF -> o_mem_ack one cycle later, o_mem_data=0xBEEF, cyc low after ack, busy=0.
- Burst write: 3 writes to 0x10, 0x11, 0x12 with next=1,1,0, data 0xA1/0xA2/0xA3 -> cyc stays high across all, stb low in HOLD gaps, wb_adr/wb_o_dat match each beat, cyc drops after the 3rd ack.
- Retry: slave returns wb_rty twice, then wb_ack -> two BACKOFF cycles with stb=0, the same wb_adr reissued, single o_mem_ack.
- Retry exhaustion: MAX_RETRY=3, slave returns wb_rty 4 times -> o_mem_err pulse after the 4th, no ack, IDLE.
- Simultaneous wb_ack+wb_err -> treated as ack. Separately, wb_err during a burst with next=1 -> cyc drops, o_mem_err pulse.
- Reset mid-STROBE -> next cycle cyc=stb=0, busy=0, no ack/err; with TIMEOUT_EN and TIMEOUT_CYC=8, a silent slave -> o_mem_err after 8 stb cycles.
